// File: rtl/mont_pkg.sv
// mont_pkg: shared widths and FSM encoding for the power-of-two modular reducer.
package mont_pkg;
    localparam int WIDTH = 2048;
    localparam int KW    = 12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/mont_dbl_sub.sv
// mont_dbl_sub: one doubling step mod n; requires r < n so one subtraction suffices.
module mont_dbl_sub
    import mont_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] n,
    output logic [W-1:0] nxt
);
    logic [W:0] w_d;
    logic       w_ge;

    // Doubling keeps the carry in bit W; the difference always fits back in W bits.
    assign w_d  = {r, 1'b0};
    assign w_ge = w_d >= {1'b0, n};
    assign nxt  = w_ge ? w_d[W-1:0] - n : w_d[W-1:0];
endmodule

// File: rtl/mont_pow2_mod.sv
// mont_pow2_mod: computes 2^k mod n by k doubling steps, one per clock.
module mont_pow2_mod
    import mont_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int KB = KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  n,
    input  logic [KB-1:0] k,
    input  logic          enable,
    output logic [W-1:0]  result,
    output logic          finish,
    output logic          busy,
    output logic          err
);
    state_t        r_state, w_next;
    logic [W-1:0]  r_n, r_r, r_result, w_r_nxt;
    logic [KB-1:0] r_cnt;
    logic          r_err;
    logic          w_last;

    mont_dbl_sub #(.W(W)) u_dbl (.r(r_r), .n(r_n), .nxt(w_r_nxt));

    assign w_last = r_err || r_cnt == '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = enable ? CALC : IDLE;
            CALC:    w_next = w_last ? DONE : CALC;
            DONE:    w_next = enable ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n      <= '0;
            r_r      <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else if (r_state == IDLE && enable) begin
            r_n   <= n;
            r_cnt <= k;
            r_err <= n == '0;
            r_r   <= (n <= W'(1)) ? '0 : W'(1);
        end else if (r_state == CALC) begin
            if (w_last) begin
                r_result <= r_r;
            end else begin
                r_r   <= w_r_nxt;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign result = r_result;
    assign err    = r_err;
    assign finish = r_state == DONE;
    assign busy   = r_state == CALC;
endmodule

// File: tb/tb_mont_pow2_mod.sv
// tb_mont_pow2_mod: directed runs with a scoreboard of expected result/err/latency.
module tb_mont_pow2_mod;
    localparam int W  = 2048;
    localparam int KB = 12;

    typedef struct {
        logic [W-1:0] res;
        logic         e;
        int           lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  n = '0;
    logic [KB-1:0] k = '0;
    logic          enable = 1'b0;
    logic [W-1:0]  result;
    logic          finish, busy, err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mont_pow2_mod #(.W(W), .KB(KB)) dut (
        .clk(clk), .rst_n(rst_n), .n(n), .k(k), .enable(enable),
        .result(result), .finish(finish), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (low 64 bits)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic start(input logic [W-1:0] nn, input logic [KB-1:0] kk,
                         input logic [W-1:0] res, input logic e);
        exp_t x;
        @(negedge clk);
        n = nn;
        k = kk;
        enable = 1'b1;
        x.res = res;
        x.e   = e;
        x.lat = e ? 1 : int'(kk) + 1;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int   cyc = 0;
        exp_t x;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!finish && cyc < 5000);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, " latency"}, W'(cyc), W'(x.lat));
            chk({tag, " result"}, result, x.res);
            chk({tag, " err"}, W'(err), W'(x.e));
            chk({tag, " busy in DONE"}, W'(busy), '0);
        end
    endtask

    task automatic release_run(input string tag);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " finish cleared"}, W'(finish), '0);
    endtask

    logic [W-1:0] big_n, big_exp;

    initial begin
        big_n = '0;
        big_n[W-1] = 1'b1;
        big_n[0] = 1'b1;
        big_exp = {1'b0, {(W-1){1'b1}}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, '0);
        chk("reset finish", W'(finish), '0);
        chk("reset busy", W'(busy), '0);
        chk("reset err", W'(err), '0);
        @(negedge clk);
        rst_n = 1'b1;

        start(W'(13), 12'd0, W'(1), 1'b0);
        wait_done("n13k0");
        repeat (3) @(negedge clk);
        chk("n13k0 busy held low", W'(busy), '0);
        chk("n13k0 finish held", W'(finish), W'(1));
        release_run("n13k0");

        start(W'(13), 12'd5, W'(6), 1'b0);
        n = W'(7);
        k = 12'd3;
        wait_done("n13k5 n-change");
        release_run("n13k5");

        start(W'(1), 12'd7, '0, 1'b0);
        wait_done("n1k7");
        release_run("n1k7");

        start('0, 12'd100, '0, 1'b1);
        wait_done("n0k100");
        release_run("n0k100");

        start(big_n, 12'd2048, big_exp, 1'b0);
        wait_done("carry");

        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!finish || busy) bad++;
            end
            chk("enable held no restart", W'(bad), '0);
        end
        chk("held result", result, big_exp);
        release_run("handshake");
        start(W'(11), 12'd10, W'(1), 1'b0);
        wait_done("n11k10 restart");

        @(negedge clk);
        enable = 1'b0;
        start(W'(13), 12'd5, W'(6), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("async rst result", result, '0);
        chk("async rst finish", W'(finish), '0);
        chk("async rst busy", W'(busy), '0);
        chk("async rst err", W'(err), '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start(W'(13), 12'd5, W'(6), 1'b0);
        wait_done("after reset");
        release_run("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
